// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register for the 32-bit MIPS-style Scipio core.
// Captures the fetched instruction, its PC and side-band bits, and exposes decoded fields to ID.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   if_valid/pc/inst    fetch-side instruction and PC
//   if_pred_taken       branch predictor taken flag
//   if_fetch_fault      fetch address/bus error flag
//   id_stall            ID cannot accept: hold contents
//   flush               squash contents (mispredict/exception)
//   if_ready            ~id_stall
//   id_*                registered bundle and combinational field slices of id_inst
//
// Optional build macro IFID_PERF_CNT_EN adds saturating 32-bit counters
// stall_cnt (stall without flush) and flush_cnt (flush cycles).
module if_id_pipe_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    input  logic            if_pred_taken,
    input  logic            if_fetch_fault,
    input  logic            id_stall,
    input  logic            flush,
    output logic            if_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_inst,
    output logic            id_pred_taken,
    output logic            id_fetch_fault,
    output logic [5:0]      id_opcode,
    output logic [4:0]      id_rs,
    output logic [4:0]      id_rt,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_shamt,
    output logic [5:0]      id_funct,
    output logic [15:0]     id_imm16,
    output logic [25:0]     id_target
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

    assign if_ready = ~id_stall;

    // PC and PC+4 survive a flush so that exception/redirect logic in ID
    // can still see where the squashed slot came from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (!flush && !id_stall) begin
            id_pc       <= if_pc;
            id_pc_plus4 <= if_pc + XLEN'(4);
        end
    end

    // Valid, instruction and side-band bits: an invalid fetch loads a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid       <= 1'b0;
            id_inst        <= NOP;
            id_pred_taken  <= 1'b0;
            id_fetch_fault <= 1'b0;
        end else if (flush) begin
            id_valid       <= 1'b0;
            id_inst        <= NOP;
            id_pred_taken  <= 1'b0;
            id_fetch_fault <= 1'b0;
        end else if (!id_stall) begin
            id_valid       <= if_valid;
            id_inst        <= if_valid ? if_inst : NOP;
            id_pred_taken  <= if_valid & if_pred_taken;
            id_fetch_fault <= if_valid & if_fetch_fault;
        end
    end

    // Field slices are deliberately not gated by id_valid; a bubble
    // decodes to whatever NOP_INST holds.
    assign id_opcode = id_inst[31:26];
    assign id_rs     = id_inst[25:21];
    assign id_rt     = id_inst[20:16];
    assign id_rd     = id_inst[15:11];
    assign id_shamt  = id_inst[10:6];
    assign id_funct  = id_inst[5:0];
    assign id_imm16  = id_inst[15:0];
    assign id_target = id_inst[25:0];

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_stall && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed self-checking bench for if_id_pipe_reg.
// Reset, streaming, stall, flush, bubble and PC wrap cases.
module tb_if_id_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_pred_taken;
    logic        if_fetch_fault;
    logic        id_stall;
    logic        flush;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        id_pred_taken;
    logic        id_fetch_fault;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_target;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    int          exp_stall;
    int          exp_flush;
`endif

    int n_cmp = 0;
    int n_err = 0;

    if_id_pipe_reg dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_pred_taken  (if_pred_taken),
        .if_fetch_fault (if_fetch_fault),
        .id_stall       (id_stall),
        .flush          (flush),
        .if_ready       (if_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_inst        (id_inst),
        .id_pred_taken  (id_pred_taken),
        .id_fetch_fault (id_fetch_fault),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_shamt       (id_shamt),
        .id_funct       (id_funct),
        .id_imm16       (id_imm16),
        .id_target      (id_target)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] w);
        check({tag, ".opcode"}, 32'(id_opcode), 32'(w[31:26]));
        check({tag, ".rs"},     32'(id_rs),     32'(w[25:21]));
        check({tag, ".rt"},     32'(id_rt),     32'(w[20:16]));
        check({tag, ".rd"},     32'(id_rd),     32'(w[15:11]));
        check({tag, ".shamt"},  32'(id_shamt),  32'(w[10:6]));
        check({tag, ".funct"},  32'(id_funct),  32'(w[5:0]));
        check({tag, ".imm16"},  32'(id_imm16),  32'(w[15:0]));
        check({tag, ".target"}, 32'(id_target), 32'(w[25:0]));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".valid"}, 32'(id_valid), 32'd0);
        check({tag, ".pc"},    id_pc,         32'd0);
        check({tag, ".pc4"},   id_pc_plus4,   32'd0);
        check({tag, ".inst"},  id_inst,       32'd0);
        check({tag, ".pred"},  32'(id_pred_taken),  32'd0);
        check({tag, ".fault"}, 32'(id_fetch_fault), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] pc;

        rst            = 1'b0;
        if_valid       = 1'b1;
        if_pc          = $urandom;
        if_inst        = $urandom;
        if_pred_taken  = 1'b1;
        if_fetch_fault = 1'b1;
        id_stall       = 1'b0;
        flush          = 1'b0;

        // Reset held across edges
        step();
        step();
        chk_reset("rst0");
        check("rst0.ready", 32'(if_ready), 32'd1);

        // Release reset; first edge loads the example word
        rst     = 1'b1;
        if_pc   = 32'h0000_0100;
        if_inst = 32'h8C22_0004;
        if_pred_taken  = 1'b0;
        if_fetch_fault = 1'b0;
        step();
        check("ex.valid",  32'(id_valid),  32'd1);
        check("ex.pc",     id_pc,          32'h100);
        check("ex.pc4",    id_pc_plus4,    32'h104);
        check("ex.inst",   id_inst,        32'h8C22_0004);
        check("ex.opcode", 32'(id_opcode), 32'h23);
        check("ex.rs",     32'(id_rs),     32'd1);
        check("ex.rt",     32'(id_rt),     32'd2);
        check("ex.imm16",  32'(id_imm16),  32'h0004);

        // Stream 10 instructions
        for (int i = 0; i < 10; i++) begin
            w  = $urandom;
            pc = 32'h100 + 32'(4 * i);
            if_inst        = w;
            if_pc          = pc;
            if_pred_taken  = i[0];
            if_fetch_fault = (i == 3);
            step();
            check("st.inst",  id_inst,     w);
            check("st.pc",    id_pc,       pc);
            check("st.pc4",   id_pc_plus4, pc + 32'd4);
            check("st.valid", 32'(id_valid), 32'd1);
            check("st.pred",  32'(id_pred_taken), 32'(i[0]));
            check("st.fault", 32'(id_fetch_fault), (i == 3) ? 32'd1 : 32'd0);
            chk_fields("st", w);
        end

        // Stall holds contents for 3 cycles
        if_inst        = 32'h1234_5678;
        if_pc          = 32'h0000_0200;
        if_pred_taken  = 1'b1;
        if_fetch_fault = 1'b0;
        step();
        check("ld.inst", id_inst, 32'h1234_5678);
        id_stall = 1'b1;
        #1;
        check("stl.ready", 32'(if_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if_inst       = $urandom;
            if_pc         = 32'h300 + 32'(4 * i);
            if_pred_taken = 1'b0;
            if_valid      = i[0];
            step();
            check("stl.inst",  id_inst,     32'h1234_5678);
            check("stl.pc",    id_pc,       32'h200);
            check("stl.pc4",   id_pc_plus4, 32'h204);
            check("stl.valid", 32'(id_valid), 32'd1);
            check("stl.pred",  32'(id_pred_taken), 32'd1);
            check("stl.ready", 32'(if_ready), 32'd0);
        end

        // Flush wins over stall; PC holds
        flush    = 1'b1;
        if_valid = 1'b1;
        step();
        check("fl.valid", 32'(id_valid), 32'd0);
        check("fl.inst",  id_inst,       32'd0);
        check("fl.pc",    id_pc,         32'h200);
        check("fl.pc4",   id_pc_plus4,   32'h204);
        check("fl.pred",  32'(id_pred_taken), 32'd0);
        check("fl.ready", 32'(if_ready), 32'd0);
        chk_fields("fl", 32'd0);

        // Flush without stall: if_ready back high, PC still holds
        id_stall = 1'b0;
        #1;
        check("fl2.ready", 32'(if_ready), 32'd1);
        step();
        check("fl2.pc",    id_pc,         32'h200);
        check("fl2.valid", 32'(id_valid), 32'd0);
        flush = 1'b0;

        // Bubble with all-ones word and PC wrap
        if_valid       = 1'b0;
        if_inst        = 32'hFFFF_FFFF;
        if_pc          = 32'hFFFF_FFFC;
        if_pred_taken  = 1'b1;
        if_fetch_fault = 1'b1;
        step();
        check("bub.inst",  id_inst,       32'd0);
        check("bub.valid", 32'(id_valid), 32'd0);
        check("bub.pc",    id_pc,         32'hFFFF_FFFC);
        check("bub.pc4",   id_pc_plus4,   32'd0);
        check("bub.pred",  32'(id_pred_taken),  32'd0);
        check("bub.fault", 32'(id_fetch_fault), 32'd0);
        chk_fields("bub", 32'd0);

        // Valid load with fault flag set
        if_valid = 1'b1;
        if_inst  = 32'hAABB_CCDD;
        if_pc    = 32'h0000_0400;
        step();
        check("ld2.inst",  id_inst, 32'hAABB_CCDD);
        check("ld2.fault", 32'(id_fetch_fault), 32'd1);

        // Asynchronous reset mid-cycle during a stall
        id_stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_reset("arst");
        check("arst.ready", 32'(if_ready), 32'd0);
        step();
        chk_reset("arst2");

        // Release: first edge loads inputs
        id_stall = 1'b0;
        if_inst  = 32'h0041_0820;
        if_pc    = 32'h0000_0500;
        if_pred_taken  = 1'b0;
        if_fetch_fault = 1'b0;
        #2;
        rst = 1'b1;
        step();
        check("rel.inst",  id_inst,       32'h0041_0820);
        check("rel.pc",    id_pc,         32'h500);
        check("rel.valid", 32'(id_valid), 32'd1);
        chk_fields("rel", 32'h0041_0820);

`ifdef IFID_PERF_CNT_EN
        // Reset clears counters, then 4 stalls and 2 flushes
        rst = 1'b0;
        #1;
        check("pc.rst_s", stall_cnt, 32'd0);
        check("pc.rst_f", flush_cnt, 32'd0);
        rst = 1'b1;
        id_stall = 1'b1;
        for (int i = 0; i < 4; i++) step();
        id_stall = 1'b0;
        flush    = 1'b1;
        for (int i = 0; i < 2; i++) step();
        flush = 1'b0;
        step();
        check("pc.stall", stall_cnt, 32'd4);
        check("pc.flush", flush_cnt, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("pc.clr_s", stall_cnt, 32'd0);
        check("pc.clr_f", flush_cnt, 32'd0);
        rst = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Pipeline register between the instruction-fetch (IF) and instruction-decode (ID) stages of the 32-bit MIPS-style Scipio core. Each cycle it captures the fetched instruction, its PC and fetch side-band bits, and presents them to ID together with combinationally extracted instruction fields. Supports ID-side stall (hold) and pipeline flush (bubble insertion).

Parameters:
XLEN, 32, width of PC and instruction words
NOP_INST, 32'h0000_0000, instruction word inserted for bubbles and flushes

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low
if_valid  in  1  IF presents a valid instruction
if_pc  in  XLEN  PC of fetched instruction
if_inst  in  XLEN  fetched instruction word
if_pred_taken  in  1  branch predictor taken flag for this instruction
if_fetch_fault  in  1  fetch address/bus error for this instruction
id_stall  in  1  ID cannot accept; hold register contents
flush  in  1  squash register contents (branch mispredict/exception)
if_ready  out  1  IF may advance; equals ~id_stall (combinational)
id_valid  out  1  registered valid
id_pc  out  XLEN  registered PC
id_pc_plus4  out  XLEN  registered if_pc+4
id_inst  out  XLEN  registered instruction
id_pred_taken  out  1  registered predictor flag
id_fetch_fault  out  1  registered fault flag
id_opcode  out  6  id_inst[31:26]
id_rs  out  5  id_inst[25:21]
id_rt  out  5  id_inst[20:16]
id_rd  out  5  id_inst[15:11]
id_shamt  out  5  id_inst[10:6]
id_funct  out  6  id_inst[5:0]
id_imm16  out  16  id_inst[15:0]
id_target  out  26  id_inst[25:0]

Behaviour:
- rst low (asynchronous, any time, including mid-stall): id_valid=0, id_pc=0, id_pc_plus4=0, id_inst=NOP_INST, id_pred_taken=0, id_fetch_fault=0. Release is synchronised by the clock; first capture occurs on the first rising edge with rst high.
- Register update on each rising clk, with priority flush > id_stall > load.
- flush=1: id_valid=0, id_inst=NOP_INST, id_pred_taken=0, id_fetch_fault=0; id_pc and id_pc_plus4 hold. Flush wins over a simultaneous stall.
- id_stall=1 (no flush): all registers hold their values.
- Load (neither): id_pc<=if_pc, id_pc_plus4<=if_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), id_valid<=if_valid. If if_valid=1: id_inst<=if_inst, id_pred_taken<=if_pred_taken, id_fetch_fault<=if_fetch_fault. If if_valid=0: id_inst<=NOP_INST, id_pred_taken<=0, id_fetch_fault<=0 (bubble).
- Latency: one cycle from IF inputs to ID outputs.
- Field outputs are pure combinational slices of id_inst. They are not gated by id_valid. A bubble therefore decodes to all-zero fields.
- if_ready=~id_stall, independent of flush and rst.

Optional Feature:
IFID_PERF_CNT_EN. When defined, two additional 32-bit outputs are present:
- stall_cnt: increments on each clock with id_stall=1 and flush=0.
- flush_cnt: increments on each clock with flush=1.
- Both counters saturate at 32'hFFFF_FFFF and clear on rst.

When not defined, both ports and their logic are absent, and the block's behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=0 mid-cycle with random inputs -> all outputs zero immediately, id_inst=0; after rst=1, the first edge loads inputs.
- Stream: 10 cycles, if_valid=1, random if_inst, if_pc=0x100 stepping by 4 -> at each next edge, id_inst/id_pc match the prior inputs, id_pc_plus4=id_pc+4, fields are the correct slices. Example: inst 0x8C220004 -> opcode 0x23, rs 1, rt 2, imm16 0x0004.
- Stall: load inst 0x12345678, then id_stall=1 for 3 cycles with changing inputs -> outputs hold 0x12345678; if_ready=0 during the stall.
- Flush vs stall: flush=1 and id_stall=1 together -> id_valid=0, id_inst=0, id_pc unchanged.
- Bubble and wrap: if_valid=0 with if_inst=0xFFFFFFFF -> id_inst=0, id_valid=0; if_pc=0xFFFFFFFC -> id_pc_plus4=0.
- With IFID_PERF_CNT_EN: 4 stall cycles and 2 flush cycles -> stall_cnt=4, flush_cnt=2; rst clears both to 0.
